shift_sequencer: RTL and testbench

//  Shares one combinational shift unit (3-bit amount, 0=left/else=right) between two requesters.

---
 rtl/shift_sequencer_if.sv | 46 ++++
 rtl/shift_sequencer.sv | 100 ++++++++++
 tb/tb_shift_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Bus bundle between two requesters, the result consumer, the shared shift unit and shift_sequencer.
// The slave modport is the sequencer. The master modport is the surrounding clients and the shifter.
interface shift_sequencer_if #(
  parameter int unsigned N  = 15,
  parameter int unsigned AW = 4
);
  logic          req0_valid;
  logic          req0_ready;
  logic [N-1:0]  req0_data;
  logic [AW-1:0] req0_amount;
  logic          req0_dir;

  logic          req1_valid;
  logic          req1_ready;
  logic [N-1:0]  req1_data;
  logic [AW-1:0] req1_amount;
  logic          req1_dir;

  logic          resp_valid;
  logic          resp_ready;
  logic [N-1:0]  resp_data;
  logic          resp_id;

  logic [N-1:0]  sh_data;
  logic [2:0]    sh_shift;
  logic [2:0]    sh_dir;
  logic [N-1:0]  sh_result;

  modport slave (
    input  req0_valid, req0_data, req0_amount, req0_dir,
    input  req1_valid, req1_data, req1_amount, req1_dir,
    input  resp_ready, sh_result,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id,
    output sh_data, sh_shift, sh_dir
  );

  modport master (
    output req0_valid, req0_data, req0_amount, req0_dir,
    output req1_valid, req1_data, req1_amount, req1_dir,
    output resp_ready, sh_result,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id,
    input  sh_data, sh_shift, sh_dir
  );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin sharing of one 3-bit combinational shifter between two requesters.
// Shift amounts above 7 are split into several passes of at most 7 bits each.
module shift_sequencer #(
  parameter int unsigned N  = 15,
  parameter int unsigned AW = 4
) (
  input logic              clk,
  input logic              rst,
  shift_sequencer_if.slave bus
);
  localparam logic [AW-1:0] MAX_STEP = AW'(7);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e        state_q;
  logic [N-1:0]  work_q;
  logic [AW-1:0] rem_q;
  logic [AW-1:0] rem_d;
  logic          dir_q;
  logic          id_q;
  logic          last_q;

  logic          any_req_c;
  logic          gnt_id_c;
  logic          accept_c;
  logic [AW-1:0] step_c;
  logic [N-1:0]  sel_data_c;
  logic [AW-1:0] sel_amount_c;
  logic          sel_dir_c;

  // Grant the sole valid requester, or the one not served last when both are valid.
  always_comb begin
    any_req_c = bus.req0_valid | bus.req1_valid;
    gnt_id_c  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id_c = ~last_q;
    end else if (bus.req1_valid) begin
      gnt_id_c = 1'b1;
    end
    accept_c     = (state_q == IDLE) && !rst && any_req_c;
    sel_data_c   = gnt_id_c ? bus.req1_data   : bus.req0_data;
    sel_amount_c = gnt_id_c ? bus.req1_amount : bus.req0_amount;
    sel_dir_c    = gnt_id_c ? bus.req1_dir    : bus.req0_dir;
  end

  // Each pass consumes up to 7 bits of the remaining amount.
  always_comb begin
    step_c = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;
    rem_d  = rem_q - step_c;
  end

  assign bus.req0_ready = accept_c && !gnt_id_c;
  assign bus.req1_ready = accept_c &&  gnt_id_c;

  assign bus.sh_data  = work_q;
  assign bus.sh_shift = (state_q == SHIFT) ? 3'(step_c) : 3'd0;
  assign bus.sh_dir   = (state_q == SHIFT) ? {2'b00, dir_q} : 3'd0;

  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = work_q;
  assign bus.resp_id    = id_q;

  // last_q resets to 1 so that req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            work_q  <= sel_data_c;
            rem_q   <= sel_amount_c;
            dir_q   <= sel_dir_c;
            id_q    <= gnt_id_c;
            last_q  <= gnt_id_c;
            state_q <= (sel_amount_c == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work_q <= bus.sh_result;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: a vector table of single requests plus hand-written
// arbitration, back-pressure and mid-operation reset sequences.
module tb_shift_sequencer;
  localparam int unsigned N  = 15;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_sequencer_if #(.N(N), .AW(AW)) bus ();

  shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model of the attached shift unit: logical, zero fill.
  assign bus.sh_result = bus.sh_dir[0] ? (bus.sh_data >> bus.sh_shift)
                                       : (bus.sh_data << bus.sh_shift);

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic          id;
    logic [N-1:0]  data;
    logic [AW-1:0] amt;
    logic          dir;
    logic [N-1:0]  exp_data;
    int            exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [N-1:0] d,
                         input logic [AW-1:0] a, input logic dr);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_amount = a; bus.req0_dir = dr;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_amount = a; bus.req1_dir = dr;
    end
  endtask

  task automatic wait_resp(input string name, output int edges);
    edges = 0;
    while (!bus.resp_valid && edges < 30) begin
      step();
      edges++;
    end
    if (!bus.resp_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout waiting for resp_valid", name);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int extra;
    logic [2:0] first_step;
    first_step = (v.amt > 4'd7) ? 3'd7 : 3'(v.amt);
    set_req(v.id, 1'b1, v.data, v.amt, v.dir);
    #1;
    check($sformatf("v%0d ready0", idx), 32'(bus.req0_ready), 32'(!v.id));
    check($sformatf("v%0d ready1", idx), 32'(bus.req1_ready), 32'(v.id));
    step();
    set_req(v.id, 1'b0, '0, '0, 1'b0);
    lat = 1;
    check($sformatf("v%0d sh_shift", idx), 32'(bus.sh_shift), 32'(first_step));
    if (v.amt != '0) begin
      check($sformatf("v%0d sh_dir", idx), 32'(bus.sh_dir), 32'({2'b00, v.dir}));
      check($sformatf("v%0d sh_data", idx), 32'(bus.sh_data), 32'(v.data));
    end
    wait_resp($sformatf("v%0d", idx), extra);
    lat += extra;
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d resp_data", idx), 32'(bus.resp_data), 32'(v.exp_data));
    check($sformatf("v%0d resp_id", idx), 32'(bus.resp_id), 32'(v.id));
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check($sformatf("v%0d resp_valid drop", idx), 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int edges;
    logic saw_resp;

    vecs[0] = '{1'b0, 15'h0001, 4'd10, 1'b0, 15'h0400, 3};
    vecs[1] = '{1'b1, 15'h4000, 4'd14, 1'b1, 15'h0001, 3};
    vecs[2] = '{1'b0, 15'h1234, 4'd0,  1'b0, 15'h1234, 1};
    vecs[3] = '{1'b1, 15'h0001, 4'd15, 1'b0, 15'h0000, 4};
    vecs[4] = '{1'b0, 15'h7FFF, 4'd7,  1'b1, 15'h00FF, 2};
    vecs[5] = '{1'b1, 15'h00FF, 4'd8,  1'b0, 15'h7F00, 3};
    vecs[6] = '{1'b0, 15'h1234, 4'd1,  1'b1, 15'h091A, 2};
    vecs[7] = '{1'b1, 15'h0003, 4'd14, 1'b0, 15'h4000, 3};

    rst = 1'b1;
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_data", 32'(bus.resp_data), 32'd0);
    check("reset resp_id", 32'(bus.resp_id), 32'd0);
    check("reset sh_bus", {bus.sh_data, 11'd0, bus.sh_shift, bus.sh_dir}, 32'd0);
    check("reset readies", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Both requesters valid straight out of reset: strict 0,1,0,1 alternation.
    rst = 1'b1;
    set_req(1'b0, 1'b1, 15'h0001, 4'd1, 1'b0);
    set_req(1'b1, 1'b1, 15'h0100, 4'd1, 1'b1);
    step();
    check("rr ready during reset", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    step();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    #1;
    check("rr first grant", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
    for (int k = 0; k < 4; k++) begin
      wait_resp($sformatf("rr%0d", k), edges);
      check($sformatf("rr%0d resp_id", k), 32'(bus.resp_id), 32'(k % 2));
      check($sformatf("rr%0d resp_data", k), 32'(bus.resp_data),
            (k % 2 == 0) ? 32'h0002 : 32'h0080);
      step();
    end
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    bus.resp_ready = 1'b0;

    // Back-pressure in DONE: result held, no grants while requesters keep asking.
    set_req(1'b0, 1'b1, 15'h0001, 4'd3, 1'b0);
    set_req(1'b1, 1'b1, 15'h7FFF, 4'd5, 1'b1);
    #1;
    check("bp grant req0", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);
    step();
    bus.req0_data = 15'h5555;
    wait_resp("bp", edges);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold%0d", c),
            {14'd0, bus.resp_valid, bus.resp_id, bus.req0_ready, bus.req1_ready, 1'b0, bus.resp_data},
            {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0008});
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("bp next grant req1", 32'({bus.req0_ready, bus.req1_ready}), 32'b01);
    set_req(1'b0, 1'b0, '0, '0, 1'b0);
    set_req(1'b1, 1'b0, '0, '0, 1'b0);

    // Reset during the second pass of a 14-bit shift drops the command.
    set_req(1'b1, 1'b1, 15'h4000, 4'd14, 1'b1);
    #1;
    step();
    set_req(1'b1, 1'b0, '0, '0, 1'b0);
    step();
    check("rst second pass sh_shift", 32'(bus.sh_shift), 32'd7);
    rst = 1'b1;
    step();
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_data", 32'(bus.resp_data), 32'd0);
    check("rst sh_shift", 32'(bus.sh_shift), 32'd0);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    saw_resp = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.resp_valid) saw_resp = 1'b1;
    end
    check("rst no response", 32'(saw_resp), 32'd0);
    bus.resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 15'h0001, 4'd1, 1'b0);
    set_req(1'b1, 1'b1, 15'h0001, 4'd1, 1'b0);
    #1;
    check("rst pointer favours req0", 32'({bus.req0_ready, bus.req1_ready}), 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
